io_timer: RTL and testbench

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_timer_pkg.sv | 26 ++
 rtl/io_timer_prescaler.sv | 34 +++
 rtl/io_timer.sv | 169 ++++++++++++++++
 tb/tb_io_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_pkg.sv
// io_timer shared definitions: register offsets, CTRL/STATUS bit
// positions, default io-bus base, register width and FSM state type.
package io_timer_pkg;

  localparam int REG_W = 32;

  localparam logic [REG_W-1:0] IO_TIMER_BASE_DEFAULT = 32'hFFFF_FC20;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STATUS_EXP  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer prescaler: free-running divider while run=1, tick for one
// cycle when cnt == div. Ports: clk, rst (sync, low), run, div, clr, tick.
module io_timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] div,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = run & (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: io-bus mapped down-counter with reload, W1C expiry flag, irq.
// Ports: clk, rst (sync, low), addr/ce/iow/wdata/rdata bus, irq. Macro IO_TIMER_PRESCALE_EN.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IO_TIMER_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             ce,
  input  logic             iow,
  input  logic [REG_W-1:0] wdata,
  output logic [REG_W-1:0] rdata,
  output logic             irq
);

  tmr_state_e       state_q, state_d;
  logic             reload_q, reload_d;
  logic             irq_en_q, irq_en_d;
  logic [REG_W-1:0] load_q, load_d;
  logic [REG_W-1:0] count_q, count_d;
  logic             exp_q, exp_d;

  logic       hit, rd_hit, wr_hit;
  logic [2:0] sel;
  logic       sel_ctrl, sel_load, sel_count, sel_status, sel_psc;
  logic       wr_ctrl, wr_load, wr_status, wr_psc;
  logic       run, tick, expire;
  logic       unused_addr;

  assign unused_addr = ^addr[1:0];

  assign hit    = ce & (addr[31:5] == BASE_ADDR[31:5]);
  assign rd_hit = hit & ~iow;
  assign wr_hit = hit & iow;
  assign sel    = addr[4:2];

  assign sel_ctrl   = (sel == OFF_CTRL);
  assign sel_load   = (sel == OFF_LOAD);
  assign sel_count  = (sel == OFF_COUNT);
  assign sel_status = (sel == OFF_STATUS);
  assign sel_psc    = (sel == OFF_PRESCALE);

  assign wr_ctrl   = wr_hit & sel_ctrl;
  assign wr_load   = wr_hit & sel_load;
  assign wr_status = wr_hit & sel_status;
  assign wr_psc    = wr_hit & sel_psc;

  assign run    = (state_q == ST_RUN);
  assign expire = tick & (count_q == '0);

`ifdef IO_TIMER_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic        psc_clr;

  // Restart the divider whenever the timer (re)enters RUN or the ratio changes.
  assign psc_clr = wr_psc
                 | (wr_ctrl & wdata[CTRL_EN] & ~run);

  always_comb begin
    prescale_d = prescale_q;
    if (wr_psc) begin
      prescale_d = wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  io_timer_prescaler u_psc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .div  (prescale_q),
    .clr  (psc_clr),
    .tick (tick)
  );
`else
  logic unused_psc;
  assign unused_psc = wr_psc;
  assign tick       = run;
`endif

  // Tick effects first; software writes then override state and count,
  // while a hardware expiry always wins over a W1C clear of EXP.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    irq_en_d = irq_en_q;
    load_d   = load_q;
    count_d  = count_q;
    exp_d    = exp_q;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else if (reload_q) begin
        count_d = load_q;
      end else begin
        state_d = ST_DONE;
      end
    end

    if (wr_status & wdata[STATUS_EXP]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end

    if (wr_ctrl) begin
      reload_d = wdata[CTRL_RELOAD];
      irq_en_d = wdata[CTRL_IRQ_EN];
      state_d  = wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
    end

    if (wr_load) begin
      load_d  = wdata;
      count_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      reload_q <= 1'b0;
      irq_en_q <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      irq_en_q <= irq_en_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
    end
  end

  assign irq = exp_q & irq_en_q;

  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      unique case (1'b1)
        sel_ctrl: begin
          rdata[CTRL_EN]     = run;
          rdata[CTRL_RELOAD] = reload_q;
          rdata[CTRL_IRQ_EN] = irq_en_q;
        end
        sel_load:   rdata = load_q;
        sel_count:  rdata = count_q;
        sel_status: rdata[STATUS_EXP] = exp_q;
`ifdef IO_TIMER_PRESCALE_EN
        sel_psc:    rdata = {16'b0, prescale_q};
`endif
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// io_timer bench: directed scenarios plus random bus traffic, every
// cycle compared against a behavioural register-level model.
module tb_io_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FC20;

  logic        clk, rst, ce, iow;
  logic [31:0] addr, wdata, rdata;
  logic        irq;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .ce    (ce),
    .iow   (iow),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit          m_run, m_reload, m_irqen, m_exp;
  logic [31:0] m_load, m_count;
  int          m_pre, m_psc;

  logic [31:0] last_rd;
  logic        last_irq;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_reg(input int idx);
    case (idx)
      0: return {29'b0, m_irqen, m_reload, m_run};
      1: return m_load;
      2: return m_count;
      3: return {31'b0, m_exp};
`ifdef IO_TIMER_PRESCALE_EN
      4: return 32'(m_pre);
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_reload = 0; m_irqen = 0; m_exp = 0;
    m_load = 0; m_count = 0; m_pre = 0; m_psc = 0;
  endtask

  task automatic model_step(input logic c, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    bit wr, tick, expire, was_run;
    int idx;
    if (!rst) begin
      model_reset();
      return;
    end
    wr      = c && w && in_win(a);
    idx     = int'(a[4:2]);
    was_run = m_run;
`ifdef IO_TIMER_PRESCALE_EN
    tick = m_run && (m_psc == m_pre);
`else
    tick = m_run;
`endif
    expire = tick && (m_count == 0);
    if (tick) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_reload) m_count = m_load;
      else m_run = 0;
    end
`ifdef IO_TIMER_PRESCALE_EN
    if (was_run) m_psc = tick ? 0 : m_psc + 1;
`endif
    if (wr && idx == 3 && d[0]) m_exp = 0;
    if (expire) m_exp = 1;
    if (wr && idx == 0) begin
      m_reload = d[1];
      m_irqen  = d[2];
`ifdef IO_TIMER_PRESCALE_EN
      if (d[0] && !was_run) m_psc = 0;
`endif
      m_run = d[0];
    end
    if (wr && idx == 1) begin
      m_load  = d;
      m_count = d;
    end
`ifdef IO_TIMER_PRESCALE_EN
    if (wr && idx == 4) begin
      m_pre = int'(d[15:0]);
      m_psc = 0;
    end
`endif
  endtask

  task automatic cycle(input logic c, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    ce = c; iow = w; addr = a; wdata = d;
    #2;
    exp_rd   = (c && !w && in_win(a)) ? m_reg(int'(a[4:2])) : 32'h0;
    last_rd  = rdata;
    last_irq = irq;
    chk("rdata", rdata, exp_rd);
    chk("irq", {31'b0, irq}, {31'b0, m_exp & m_irqen});
    @(posedge clk);
    model_step(c, w, a, d);
    #1;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d);
    cycle(1'b1, 1'b1, BASE + 32'(idx * 4), d);
  endtask

  task automatic rd_chk(input string tag, input int idx,
                        input logic [31:0] exp);
    cycle(1'b1, 1'b0, BASE + 32'(idx * 4), 32'h0);
    chk(tag, last_rd, exp);
  endtask

  initial begin
    int r;
    logic [31:0] a;
    rst = 1'b0; ce = 1'b0; iow = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) rd_chk("reset_reg", i, 32'h0);
    chk("reset_irq", {31'b0, last_irq}, 32'h0);

    wr_reg(1, 32'd3);
    wr_reg(0, 32'h5);
    rd_chk("oneshot_cnt3", 2, 32'd3);
    rd_chk("oneshot_cnt2", 2, 32'd2);
    rd_chk("oneshot_cnt1", 2, 32'd1);
    rd_chk("oneshot_cnt0", 2, 32'd0);
    rd_chk("oneshot_exp", 3, 32'd1);
    chk("oneshot_irq", {31'b0, last_irq}, 32'd1);
    rd_chk("oneshot_ctrl", 0, 32'h4);
    rd_chk("oneshot_hold", 2, 32'd0);

    wr_reg(3, 32'h1);
    rd_chk("w1c_clear", 3, 32'h0);
    wr_reg(1, 32'd2);
    wr_reg(0, 32'h7);
    rd_chk("reload_c2a", 2, 32'd2);
    rd_chk("reload_c1a", 2, 32'd1);
    rd_chk("reload_c0a", 2, 32'd0);
    rd_chk("reload_c2b", 2, 32'd2);
    rd_chk("reload_c1b", 2, 32'd1);
    rd_chk("reload_c0b", 2, 32'd0);
    wr_reg(3, 32'h1);
    rd_chk("w1c_plain", 3, 32'h0);
    wr_reg(3, 32'h1);
    rd_chk("w1c_vs_expire", 3, 32'h1);
    wr_reg(0, 32'h0);
    wr_reg(3, 32'h1);

    wr_reg(1, 32'd3);
    wr_reg(0, 32'h1);
    wr_reg(1, 32'd10);
    rd_chk("load_vs_tick", 2, 32'd10);
    wr_reg(0, 32'h0);

    wr_reg(1, 32'd0);
    wr_reg(0, 32'h3);
    wr_reg(3, 32'h1);
    rd_chk("load0_exp", 3, 32'h1);
    wr_reg(0, 32'h0);
    wr_reg(3, 32'h1);

`ifdef IO_TIMER_PRESCALE_EN
    wr_reg(4, 32'hABCD_0004);
    rd_chk("psc_rd", 4, 32'd4);
    wr_reg(1, 32'd1);
    wr_reg(0, 32'h1);
    for (int i = 0; i < 10; i++)
      rd_chk("psc_cnt", 2, (i < 5) ? 32'd1 : 32'd0);
    rd_chk("psc_exp", 3, 32'h1);
    wr_reg(0, 32'h0);
    wr_reg(3, 32'h1);
    wr_reg(4, 32'h0);
`else
    wr_reg(4, 32'h0000_0004);
    rd_chk("psc_absent", 4, 32'h0);
`endif

    wr_reg(1, 32'd5);
    wr_reg(0, 32'h5);
    rst = 1'b0;
    rd_chk("rst_mid_cnt", 2, 32'd5);
    rst = 1'b1;
    rd_chk("rst_cnt", 2, 32'd0);
    chk("rst_irq", {31'b0, last_irq}, 32'h0);
    rd_chk("rst_ctrl", 0, 32'h0);
    rd_chk("rst_load", 1, 32'h0);

    cycle(1'b1, 1'b1, BASE + 32'd36, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, BASE + 32'd36, 32'h0);
    chk("oow_read", last_rd, 32'h0);
    rd_chk("oow_nowrite", 1, 32'h0);
    cycle(1'b0, 1'b1, BASE + 32'd4, 32'h1234);
    rd_chk("ce0_nowrite", 1, 32'h0);
    cycle(1'b1, 1'b1, BASE + 32'd7, 32'd9);
    rd_chk("low_addr_ign", 1, 32'd9);
    wr_reg(2, 32'd77);
    rd_chk("count_ro", 2, 32'd9);
    wr_reg(5, 32'hFFFF_FFFF);
    rd_chk("off5_zero", 5, 32'h0);

    for (int i = 0; i < 800; i++) begin
      r   = int'($urandom_range(0, 99));
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      if (r < 30)
        cycle(1'b0, 1'($urandom), BASE + 32'($urandom_range(0, 31)),
              $urandom);
      else if (r < 55)
        cycle(1'b1, 1'b0, BASE + 32'($urandom_range(0, 31)), 32'h0);
      else if (r < 65)
        wr_reg(0, $urandom);
      else if (r < 75)
        wr_reg(1, 32'($urandom_range(0, 6)));
      else if (r < 85)
        wr_reg(3, $urandom);
      else if (r < 90)
        wr_reg(4, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3)));
      else if (r < 95) begin
        a = BASE ^ (32'h20 << $urandom_range(0, 26));
        cycle(1'b1, 1'($urandom), a, $urandom);
      end else
        wr_reg(2, $urandom);
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
